fir_mac_sequencer: RTL
======================

# fir_mac_sequencer

Sequencer that time-multiplexes one multiply-accumulate unit across the servo loop's coefficient memory to compute a 10-tap fixed-point filter output per input sample. It drives the 4-bit coefficient index into the combinational coefficient ROM and receives the signed coefficient back in the same cycle. It holds the sample delay line, accumulates one tap per clock, and scales and saturates the result. It sits between the sampled-error producer and the servo PWM/actuation stage.

## Interface
- cant_bits, 13: width of samples, coefficients and output (signed, two's complement)
- num_taps, 10: number of taps, indices 0..num_taps-1; must be ≤16
- frac_bits, 8: fractional bits of the coefficient Q-format; the product is shifted right by this amount
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- sample_in  in  cant_bits  signed input sample
- sample_valid  in  1  one-cycle strobe, sample_in valid
- estados  out  4  coefficient index to ROM (registered)
- Constantes  in  cant_bits  signed coefficient from ROM, combinational function of estados
- y_out  out  cant_bits  signed filter output (registered, held between results)
- y_valid  out  1  one-cycle pulse, y_out updated
- busy  out  1  high while a computation is in progress (state ≠ IDLE)
- overrun  out  1  one-cycle pulse, a sample_valid was dropped

## Operation
- Delay line x[0..num_taps-1], cant_bits each. Accumulator acc is signed, 2*cant_bits+4 bits (30 by default).
- FSM states: IDLE, MAC, DONE.
- IDLE, sample_valid=1: x[0]<=sample_in, x[k]<=x[k-1], acc<=0, estados<=0, go to MAC.
- IDLE, no strobe: hold; estados holds 0.
- MAC: acc <= acc + Constantes*x[estados], full-precision signed product, sign-extended.
- MAC, estados==num_taps-1: estados<=0, go to DONE.
- MAC, otherwise: estados<=estados+1.
- DONE: r = acc >>> frac_bits, arithmetic shift, truncation toward −inf.
- DONE output: y_out <= saturate(r) to [−2^(cant_bits−1), 2^(cant_bits−1)−1], i.e. [−4096, 4095]; y_valid<=1; go to IDLE.
- sample_valid while busy=1 (MAC or DONE): sample ignored, delay line untouched, overrun=1 the next cycle, computation unaffected.
- Reset values: state IDLE, estados 0, x[] all 0, acc 0, y_out 0, y_valid 0, overrun 0, busy 0.
- Reset mid-computation: abort, all of the above reset values apply the next cycle, no y_valid.

## Timing
- sample_valid accepted in cycle T, so cycles T+1..T+num_taps are MAC with estados=0..num_taps−1.
- T+num_taps+1 is DONE.
- y_valid=1 and new y_out in T+num_taps+2 (T+12 default). busy=1 in T+1..T+11.
- Throughput: one sample per num_taps+2 cycles. A sample_valid in the y_valid cycle (T+12) is accepted.
- A sample_valid in the DONE cycle (T+11) is dropped, with overrun in T+12.
- Constantes is sampled in the same cycle estados is presented; the ROM must be combinational.
- y_valid and overrun are never high two consecutive cycles for one event.

## Test plan
- Reset, then no strobes for 50 cycles -> y_valid never asserts, estados=0, busy=0, y_out=0.
- Bench ROM with coefficients {196,159,122,49,12,−25,−62,−98,−135,−172}. Impulse sample 256 followed by zeros (strobe every 12 cycles) -> successive y_out 196,159,122,49,12,−25,−62,−98,−135,−172, then 0.
- Step input: sample 256 on every strobe -> 10th output equals 46 and stays 46. Each y_valid appears exactly 12 cycles after its strobe.
- Saturation: ROM forced to 4095 and samples 4095 -> y_out=4095. Samples −4096 -> y_out=−4096.
- Overrun: strobe at T, second strobe at T+5 and at T+11 -> overrun pulses at T+6 and T+12. The result at T+12 equals the single-sample result and the delay line is unchanged. A strobe at T+12 is accepted.
- Reset asserted at T+6 mid-MAC -> no y_valid. Next strobe yields the result computed from an all-zero history plus the new sample.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: one multiply-accumulate unit is shared across all taps of a
// fixed-point FIR filter. Each accepted sample takes one tap per clock against a
// combinational coefficient ROM, then the result is scaled, saturated and
// presented on y_out with a one-cycle y_valid pulse.
module fir_mac_sequencer #(
    parameter int cant_bits = 13,
    parameter int num_taps  = 10,
    parameter int frac_bits = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [cant_bits-1:0] sample_in,
    input  logic                        sample_valid,
    output logic        [3:0]           estados,
    input  logic signed [cant_bits-1:0] Constantes,
    output logic signed [cant_bits-1:0] y_out,
    output logic                        y_valid,
    output logic                        busy,
    output logic                        overrun
);

    // Guard bits cover the growth from summing up to 16 full-precision products.
    localparam int ACC_W  = 2 * cant_bits + 4;
    localparam int PROD_W = 2 * cant_bits;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic        [3:0]            r_estados;
    logic signed [cant_bits-1:0]  r_x [0:num_taps-1];
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [cant_bits-1:0]  r_y_out;
    logic                         r_y_valid;
    logic                         r_overrun;

    logic                         w_last_tap;
    logic signed [cant_bits-1:0]  w_tap;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_scaled;

    // Clamp the scaled accumulator into the signed output range.
    function automatic logic signed [cant_bits-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = $signed({{(ACC_W-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}});
        lo = $signed({{(ACC_W-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}});
        if (v > hi)
            return hi[cant_bits-1:0];
        else if (v < lo)
            return lo[cant_bits-1:0];
        else
            return v[cant_bits-1:0];
    endfunction

    assign w_last_tap = (r_estados == 4'(num_taps - 1));
    assign w_tap      = r_x[r_estados];
    assign w_prod     = Constantes * w_tap;
    // Arithmetic shift truncates toward minus infinity.
    assign w_scaled   = r_acc >>> frac_bits;

    assign estados = r_estados;
    assign y_out   = r_y_out;
    assign y_valid = r_y_valid;
    assign overrun = r_overrun;
    assign busy    = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic: a strobe starts a run, the last tap ends it, DONE lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (sample_valid) w_next_state = MAC;
            MAC:     if (w_last_tap)   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: delay line, tap index, accumulator, and result/strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estados <= '0;
            r_acc     <= '0;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < num_taps; k++)
                r_x[k] <= '0;
        end else begin
            r_y_valid <= 1'b0;
            // A strobe that arrives while a run is in flight is dropped and flagged.
            r_overrun <= sample_valid && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    r_estados <= '0;
                    if (sample_valid) begin
                        r_x[0] <= sample_in;
                        for (int k = 1; k < num_taps; k++)
                            r_x[k] <= r_x[k-1];
                        r_acc <= '0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (w_last_tap)
                        r_estados <= '0;
                    else
                        r_estados <= r_estados + 4'd1;
                end
                DONE: begin
                    r_y_out   <= sat_out(w_scaled);
                    r_y_valid <= 1'b1;
                end
                default: r_estados <= '0;
            endcase
        end
    end

endmodule
